// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared defaults, FSM state type and burst-length decode for mem_seq_reader
package mem_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A zero length field encodes a full sweep of the memory.
  function automatic int unsigned len_decode(input int unsigned len, input int unsigned depth);
    return (len == 0) ? depth : len;
  endfunction

endpackage

// File: rtl/seq_out_fifo2.sv
// rtl/seq_out_fifo2.sv - two-entry output FIFO holding returned read words until the consumer takes them
module seq_out_fifo2
  import mem_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              do_push;
  logic              do_pop;

  // Overflow and underflow requests are dropped so the pointers never desynchronise.
  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  // Occupancy follows push minus pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Storage and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/mem_seq_reader.sv
// rtl/mem_seq_reader.sv - burst read sequencer streaming consecutive SRAM words through a two-entry buffer
module mem_seq_reader
  import mem_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  // One extra bit so a full-depth burst count fits.
  localparam int REM_W = ADDR_W + 1;

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [REM_W-1:0]  rem_q;
  logic [REM_W-1:0]  rem_d;
  logic              inflight_q;
  logic              done_q;
  logic              done_d;

  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic              pop;
  logic              rd;
  logic [2:0]        fill_after;
  logic [ADDR_W-1:0] addr_next;

  assign pop = fifo_valid && dout_ready_i;

  // Words the buffer will hold after this cycle: stored + returning - leaving.
  assign fill_after = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

  // A read is only issued when its data is guaranteed a free buffer slot on return.
  assign rd = (state_q == ST_READ) && (rem_q != '0) && (fill_after < 3'd2);

  assign addr_next = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = start_addr_i;
          rem_d   = REM_W'(len_decode(32'(len_i), DEPTH));
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (rd) begin
          addr_d = addr_next;
          rem_d  = rem_q - REM_W'(1);
        end
        if (rem_q == '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave once the last word is being handed over and nothing is still returning.
        if (fill_after == 3'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; the in-flight flag marks the cycle the memory returns data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= rd;
      done_q     <= done_d;
    end
  end

  seq_out_fifo2 #(
    .DATA_W (DATA_W)
  ) u_out_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (mem_data_i),
    .pop_i       (pop),
    .data_o      (dout_o),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign mem_addr_o   = addr_q;
  assign mem_rd_o     = rd;
  assign dout_valid_o = fifo_valid;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;

endmodule
